decoder_scan: RTL and testbench

- Parametrised successor to the team's 3-to-8 AND-gate decoder.
- Registered N-to-2^N one-hot decoder with four modes:
  - off;
  - direct decode of an input address;
  - auto-scan up;
  - auto-scan down.
- Auto-scan has programmable dwell time, a blanking gap between steps and a wrap pulse.
- Drives multiplexed LED/7-segment digit selects, or row strobes, from the top-level board logic.

---
 rtl/decoder_pkg.sv | 42 ++++
 rtl/onehot_dec.sv | 46 ++++
 rtl/decoder_scan.sv | 203 ++++++++++++++++++++
 tb/tb_decoder_scan.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
//   Shared definitions for the scanning one-hot decoder:
//     - mode_t    : encoding of the 2-bit mode input
//     - state_t   : FSM state encoding used by decoder_scan
//     - onehot()  : wide one-hot helper, callers keep the low 2^N bits
//   Supported address widths are 1..ONEHOT_SELW bits.
// ---------------------------------------------------------------------------
package decoder_pkg;

  // Mode input encoding.
  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_DIRECT = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_t;

  // FSM states.
  // HOLD shows the current scan position, GAP is the blanking interval
  // between two scan positions.
  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_DIRECT = 2'b01,
    ST_HOLD   = 2'b10,
    ST_GAP    = 2'b11
  } state_t;

  // Widest selector the helper understands, and the matching output width.
  localparam int unsigned ONEHOT_SELW = 8;
  localparam int unsigned ONEHOT_MAXW = 1 << ONEHOT_SELW;

  // One-hot encode of sel. Narrower decoders take the low 2^N bits, which
  // is exact because a zero-extended N-bit selector never reaches above them.
  function automatic logic [ONEHOT_MAXW-1:0] onehot(input logic [ONEHOT_SELW-1:0] sel);
    logic [ONEHOT_MAXW-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// ---------------------------------------------------------------------------
// onehot_dec
//   Purely combinational N-to-2^N one-hot decoder with selectable output
//   polarity. It is the parametrised form of the old 3-to-8 gate decoder;
//   any registering is left to the instantiating module.
//
// Ports
//   i_a   [N-1:0]     address to decode
//   i_en              1 = drive the selected bit active, 0 = all inactive
//   o_y   [2^N-1:0]   decoded select, active-high unless ACT_LOW=1
// ---------------------------------------------------------------------------
module onehot_dec #(
  parameter int N       = 3,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic [N-1:0]      i_a,
  input  logic              i_en,
  output logic [2**N-1:0]   o_y
);

  import decoder_pkg::*;

  localparam int W = 2**N;

  logic [ONEHOT_MAXW-1:0] w_full;
  logic [W-1:0]           w_hot;

  // Wide decode from the package helper, trimmed to this decoder's width.
  // Gating by i_en happens before polarity so "inactive" is the same level
  // in both polarities.
  always_comb begin
    w_full = onehot(ONEHOT_SELW'(i_a));
    w_hot  = i_en ? w_full[W-1:0] : '0;
    o_y    = ACT_LOW ? ~w_hot : w_hot;
  end

  // The bits above 2^N are always zero; fold them into a sink so they are
  // visibly consumed.
  generate
    if (W < ONEHOT_MAXW) begin : g_trim
      logic w_unusedHigh;
      assign w_unusedHigh = |w_full[ONEHOT_MAXW-1:W];
    end
  endgenerate

endmodule

// File: rtl/decoder_scan.sv
// ---------------------------------------------------------------------------
// decoder_scan
//   Registered N-to-2^N one-hot decoder for digit selects / row strobes.
//   Modes: off, direct decode of i_a, auto-scan up, auto-scan down.
//   Auto-scan shows each index for i_dwell+1 cycles, then blanks for BLANK
//   cycles, then advances. o_wrap pulses on the first cycle shown after the
//   scan jumps back to its start index.
//
// Parameters
//   N        address width, output width is 2^N
//   DW       width of the dwell input
//   BLANK    blank cycles between scan positions (0 = none)
//   ACT_LOW  1 = o_x active-low
//
// Ports
//   i_clk              clock, everything changes on the rising edge
//   i_rst              synchronous active-high reset, wins over i_en
//   i_en               clock enable, low freezes every register
//   i_mode  [1:0]      00 off, 01 direct, 10 scan up, 11 scan down
//   i_a     [N-1:0]    address used in direct mode
//   i_last  [N-1:0]    highest index visited while scanning
//   i_dwell [DW-1:0]   scan position is held for i_dwell+1 cycles
//   o_x     [2^N-1:0]  one-hot select
//   o_idx   [N-1:0]    currently selected index
//   o_act              o_x has an active bit
//   o_wrap             one-cycle pulse when the scan restarts at its start
// ---------------------------------------------------------------------------
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int DW      = 8,
  parameter int BLANK   = 1,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic [N-1:0]      i_a,
  input  logic [N-1:0]      i_last,
  input  logic [DW-1:0]     i_dwell,
  output logic [2**N-1:0]   o_x,
  output logic [N-1:0]      o_idx,
  output logic              o_act,
  output logic              o_wrap
);

  localparam int W  = 2**N;
  // Blank counter runs 0..BLANK-1; keep at least one bit so BLANK=0/1 still
  // elaborate cleanly.
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam logic [W-1:0]  X_IDLE     = ACT_LOW ? {W{1'b1}} : {W{1'b0}};

  mode_t          w_mode;
  state_t         r_state;
  state_t         w_state;
  logic [N-1:0]   r_idx;
  logic [N-1:0]   w_idx;
  logic [DW-1:0]  r_cnt;
  logic [DW-1:0]  w_cnt;
  logic [BW-1:0]  r_bcnt;
  logic [BW-1:0]  w_bcnt;
  logic           w_wrap;
  logic           w_act;
  logic [W-1:0]   w_x;
  logic [N-1:0]   w_advIdx;
  logic           w_advWrap;
  logic [W-1:0]   r_x;
  logic           r_act;
  logic           r_wrap;

  assign w_mode = mode_t'(i_mode);

  // Next scan position and whether reaching it counts as a wrap.
  // Any jump back to the start index counts as a wrap, including the case
  // where i_last was lowered below the current index mid-scan. The direction
  // is taken from the mode at the moment of advancing, so flipping between
  // up and down only affects the next step.
  always_comb begin
    w_advIdx  = r_idx;
    w_advWrap = 1'b0;
    if (w_mode == MODE_DOWN) begin
      if ((r_idx == '0) || (r_idx > i_last)) begin
        w_advIdx  = i_last;
        w_advWrap = 1'b1;
      end else begin
        w_advIdx = r_idx - 1'b1;
      end
    end else begin
      if (r_idx >= i_last) begin
        w_advIdx  = '0;
        w_advWrap = 1'b1;
      end else begin
        w_advIdx = r_idx + 1'b1;
      end
    end
  end

  // State register plus every registered output. Outputs are computed from
  // the next state so a direct-mode address shows up right after the edge
  // that samples it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_OFF;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_x     <= X_IDLE;
      r_act   <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (i_en) begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_bcnt  <= w_bcnt;
      r_x     <= w_x;
      r_act   <= w_act;
      r_wrap  <= w_wrap;
    end
  end

  // Next-state logic. Mode is re-evaluated every enabled cycle; leaving the
  // scan modes clears both counters, and entering them always starts a fresh
  // HOLD at the start index. The dwell compare uses >= so lowering i_dwell
  // below the running count ends the HOLD on the next cycle.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_bcnt  = r_bcnt;
    w_wrap  = 1'b0;
    case (w_mode)
      MODE_OFF: begin
        w_state = ST_OFF;
        w_cnt   = '0;
        w_bcnt  = '0;
      end
      MODE_DIRECT: begin
        w_state = ST_DIRECT;
        w_idx   = i_a;
        w_cnt   = '0;
        w_bcnt  = '0;
      end
      default: begin
        case (r_state)
          ST_HOLD: begin
            if (r_cnt >= i_dwell) begin
              w_cnt = '0;
              if (BLANK == 0) begin
                w_idx  = w_advIdx;
                w_wrap = w_advWrap;
              end else begin
                w_state = ST_GAP;
                w_bcnt  = '0;
              end
            end else begin
              w_cnt = r_cnt + 1'b1;
            end
          end
          ST_GAP: begin
            if (r_bcnt == BLANK_LAST) begin
              w_state = ST_HOLD;
              w_idx   = w_advIdx;
              w_wrap  = w_advWrap;
              w_bcnt  = '0;
            end else begin
              w_bcnt = r_bcnt + 1'b1;
            end
          end
          default: begin
            w_state = ST_HOLD;
            w_idx   = (w_mode == MODE_UP) ? '0 : i_last;
            w_cnt   = '0;
            w_bcnt  = '0;
          end
        endcase
      end
    endcase
  end

  // Output logic: a bit is lit in DIRECT and HOLD only; OFF and GAP blank
  // the select while o_idx keeps its value.
  always_comb begin
    w_act = (w_state == ST_DIRECT) || (w_state == ST_HOLD);
  end

  onehot_dec #(
    .N       (N),
    .ACT_LOW (ACT_LOW)
  ) u_dec (
    .i_a  (w_idx),
    .i_en (w_act),
    .o_y  (w_x)
  );

  assign o_x    = r_x;
  assign o_idx  = r_idx;
  assign o_act  = r_act;
  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan
//   Two decoders share all inputs: dutA with BLANK=1 and dutB with BLANK=0.
//   A behavioural model (position shown for N cycles, then a gap of BLANK
//   cycles, then step) predicts both every cycle; directed steps then add
//   hand-derived expectations for the interesting scenarios, followed by a
//   randomized run.
// ---------------------------------------------------------------------------
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] a;
  logic [2:0] last;
  logic [7:0] dwell;

  logic [7:0] xA, xB;
  logic [2:0] idxA, idxB;
  logic       actA, actB, wrapA, wrapB;

  int nPass   = 0;
  int nChecks = 0;

  // Behavioural model state, one slot per DUT.
  int blankOf[2] = '{1, 0};
  bit mScan[2];
  bit mAct[2];
  bit mWrap[2];
  bit mInGap[2];
  int mIdx[2];
  int mHeld[2];
  int mGapLeft[2];

  // Clock generation.
  always #5 clk = ~clk;

  decoder_scan #(.N(3), .DW(8), .BLANK(1), .ACT_LOW(1'b0)) dutA (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_a(a),
    .i_last(last), .i_dwell(dwell),
    .o_x(xA), .o_idx(idxA), .o_act(actA), .o_wrap(wrapA)
  );

  decoder_scan #(.N(3), .DW(8), .BLANK(0), .ACT_LOW(1'b0)) dutB (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_a(a),
    .i_last(last), .i_dwell(dwell),
    .o_x(xB), .o_idx(idxB), .o_act(actB), .o_wrap(wrapB)
  );

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Step to the next scan position using the direction currently requested.
  task automatic modelAdvance(input int k);
    if (mode == 2'b10) begin
      if (mIdx[k] >= int'(last)) begin
        mIdx[k]  = 0;
        mWrap[k] = 1'b1;
      end else begin
        mIdx[k] = mIdx[k] + 1;
      end
    end else begin
      if ((mIdx[k] == 0) || (mIdx[k] > int'(last))) begin
        mIdx[k]  = int'(last);
        mWrap[k] = 1'b1;
      end else begin
        mIdx[k] = mIdx[k] - 1;
      end
    end
    mHeld[k]  = 1;
    mAct[k]   = 1'b1;
    mInGap[k] = 1'b0;
  endtask

  // One rising edge of the model, using the inputs the DUT just sampled.
  task automatic modelStep(input int k);
    if (rst) begin
      mScan[k]  = 1'b0;
      mAct[k]   = 1'b0;
      mWrap[k]  = 1'b0;
      mInGap[k] = 1'b0;
      mIdx[k]   = 0;
      mHeld[k]  = 0;
    end else if (en) begin
      mWrap[k] = 1'b0;
      if (mode == 2'b00) begin
        mScan[k] = 1'b0;
        mAct[k]  = 1'b0;
      end else if (mode == 2'b01) begin
        mScan[k] = 1'b0;
        mIdx[k]  = int'(a);
        mAct[k]  = 1'b1;
      end else if (!mScan[k]) begin
        mScan[k]  = 1'b1;
        mIdx[k]   = (mode == 2'b10) ? 0 : int'(last);
        mHeld[k]  = 1;
        mInGap[k] = 1'b0;
        mAct[k]   = 1'b1;
      end else if (mInGap[k]) begin
        mGapLeft[k] = mGapLeft[k] - 1;
        if (mGapLeft[k] == 0) modelAdvance(k);
      end else if (mHeld[k] > int'(dwell)) begin
        if (blankOf[k] > 0) begin
          mInGap[k]   = 1'b1;
          mGapLeft[k] = blankOf[k];
          mAct[k]     = 1'b0;
        end else begin
          modelAdvance(k);
        end
      end else begin
        mHeld[k] = mHeld[k] + 1;
      end
    end
  endtask

  function automatic logic [7:0] expX(input int k);
    return mAct[k] ? (8'd1 << mIdx[k]) : 8'd0;
  endfunction

  // Compare both DUTs against the model.
  task automatic checkOutput();
    check("A.x",    32'(xA),    32'(expX(0)));
    check("A.idx",  32'(idxA),  32'(mIdx[0]));
    check("A.act",  32'(actA),  32'(mAct[0]));
    check("A.wrap", 32'(wrapA), 32'(mWrap[0]));
    check("B.x",    32'(xB),    32'(expX(1)));
    check("B.idx",  32'(idxB),  32'(mIdx[1]));
    check("B.act",  32'(actB),  32'(mAct[1]));
    check("B.wrap", 32'(wrapB), 32'(mWrap[1]));
  endtask

  // One clock: model follows the edge, outputs sampled 1ns later, inputs
  // are then free to change at the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    int expUp[13]   = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    bit actUp[13]   = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    int expDown[7]  = '{2, 1, 0, 2, 1, 0, 2};
    int nWrapA;
    int nWrapB;

    rst = 1'b1; en = 1'b1; mode = 2'b10; a = '0; last = 3'd3; dwell = 8'd1;

    // Reset held for two cycles while scan-up is requested.
    applyStimulus();
    applyStimulus();
    check("rst.x",    32'(xA),    32'h00);
    check("rst.idx",  32'(idxA),  32'd0);
    check("rst.act",  32'(actA),  32'd0);
    check("rst.wrap", 32'(wrapA), 32'd0);

    // Release: scan starts at index 0 on the next edge.
    rst = 1'b0;
    applyStimulus();
    check("start.x", 32'(xA), 32'h01);

    // Direct mode sweep.
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      applyStimulus();
      check("dir.x",   32'(xA),   32'(8'd1 << i));
      check("dir.act", 32'(actA), 32'd1);
      if (i == 5) check("dir.a5", 32'(xA), 32'h20);
    end

    // Scan up, last=3, dwell=1, one blank cycle: 12-cycle period.
    last = 3'd3; dwell = 8'd1; mode = 2'b10;
    for (int i = 0; i < 25; i++) begin
      applyStimulus();
      if (i < 13) begin
        check("up.idx", 32'(idxA), 32'(expUp[i]));
        check("up.act", 32'(actA), 32'(actUp[i]));
      end
      check("up.wrap", 32'(wrapA), (i == 12 || i == 24) ? 32'd1 : 32'd0);
    end

    // Scan down on the gapless decoder, last=2, dwell=0.
    mode = 2'b01;
    applyStimulus();
    last = 3'd2; dwell = 8'd0; mode = 2'b11;
    for (int i = 0; i < 7; i++) begin
      applyStimulus();
      check("dn.idx",  32'(idxB),  32'(expDown[i]));
      check("dn.wrap", 32'(wrapB), (i == 3 || i == 6) ? 32'd1 : 32'd0);
    end

    // Freeze at idx 2 with part of the dwell consumed, then resume.
    mode = 2'b01;
    applyStimulus();
    mode = 2'b10; last = 3'd7; dwell = 8'd3;
    for (int i = 0; i < 12; i++) applyStimulus();
    check("frz.pre", 32'(idxA), 32'd2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      check("frz.idx", 32'(idxA), 32'd2);
      check("frz.x",   32'(xA),   32'h04);
      check("frz.act", 32'(actA), 32'd1);
    end
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      check("res.idx", 32'(idxA), 32'd2);
      check("res.act", 32'(actA), 32'd1);
    end
    rst = 1'b1;
    applyStimulus();
    check("abort.x",    32'(xA),    32'h00);
    check("abort.idx",  32'(idxA),  32'd0);
    check("abort.wrap", 32'(wrapA), 32'd0);
    rst = 1'b0;

    // Lower last below the current index mid-scan.
    last = 3'd7; dwell = 8'd0;
    for (int i = 0; i < 40 && !(idxA == 3'd5 && actA); i++) applyStimulus();
    check("lc.reach5", 32'(idxA), 32'd5);
    last = 3'd3;
    for (int i = 0; i < 10 && actA; i++) applyStimulus();
    check("lc.gap", 32'(actA), 32'd0);
    applyStimulus();
    check("lc.idx",  32'(idxA),  32'd0);
    check("lc.wrap", 32'(wrapA), 32'd1);

    // last=0: index pinned at 0, wrap once per period.
    mode = 2'b01;
    applyStimulus();
    last = 3'd0; dwell = 8'd2; mode = 2'b10;
    nWrapA = 0;
    nWrapB = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      if (wrapA) nWrapA++;
      if (wrapB) nWrapB++;
      check("l0.idx", 32'(idxA), 32'd0);
    end
    check("l0.wrapsA", 32'(nWrapA), 32'd3);
    check("l0.wrapsB", 32'(nWrapB), 32'd5);

    // Randomized run against the model.
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 15) == 0) mode  = 2'($urandom_range(0, 3));
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)  last  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)  dwell = 8'($urandom_range(0, 3));
      applyStimulus();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
